// File: rtl/dfu_load_dma_ctrl.sv
// rtl/dfu_load_dma_ctrl.sv - load data-fetch controller: IDU pop, per-row DMA config writes, SRAM beat steering
module dfu_load_dma_ctrl #(
  parameter int                 INSTR_WIDTH = 256,
  parameter int                 DATA_WIDTH  = 64,
  parameter int                 AR_AW       = 16,
  parameter int                 SRAM_AW     = 10,
  parameter int                 NUM_BUF     = 4,
  parameter logic [AR_AW-1:0]   CFG_BASE    = 'h403
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   idu2dfu_load_fifo_empty,
  output logic                   dfu2idu_load_instr_req,
  input  logic [INSTR_WIDTH-1:0] idu2dfu_load_instr,
  input  logic                   idu2dfu_load_instr_vld,
  output logic                   dfu2ar_grant_req,
  input  logic                   ar2dfu_grant,
  output logic                   dfu2ar_wr_req,
  output logic                   dfu2ar_addr_vld,
  output logic                   dfu2ar_data_out_vld,
  output logic [AR_AW-1:0]       dfu2ar_addr,
  output logic [DATA_WIDTH-1:0]  dfu2ar_data_out,
  input  logic                   ar2dfu_ack,
  input  logic                   ar2dfu_data_in_vld,
  input  logic                   ar2dfu_ack_data_done,
  output logic [NUM_BUF-1:0]     sram_wr_en,
  output logic [SRAM_AW-1:0]     sram_wr_addr,
  output logic                   dfu2idu_load_instr_done,
  output logic                   dfu2ar_write_interrupt,
  output logic                   dfu2idu_load_err
);

  typedef enum logic [2:0] {IDLE, FETCH, DECODE, CFG, DATA} state_t;

  state_t             state;
  logic [15:0]        x_q;
  logic [15:0]        y_q;
  logic [7:0]         sel_q;
  logic [15:0]        stride_q;
  logic [63:0]        dram_q;
  logic [63:0]        sram_q;
  logic [63:0]        src_q;
  logic [15:0]        row_q;
  logic [SRAM_AW-1:0] beat_q;
  logic [1:0]         cfg_idx;
  logic               strobe_q;
  logic [AR_AW-1:0]   addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic               grant_req_q;
  logic               req_q;
  logic               done_q;
  logic               err_q;
  logic               irq_q;

  logic               bad_sel;
  logic               more_rows;
  logic [15:0]        stride_eff;
  logic               wr_active;
  logic               strobe;
  logic               unused_instr_bits;

  assign unused_instr_bits = ^{idu2dfu_load_instr[7:0], idu2dfu_load_instr[INSTR_WIDTH-1:192]};

  assign bad_sel    = {1'b0, sel_q} >= 9'(NUM_BUF);
  assign more_rows  = ({1'b0, row_q} + 17'd1) < {1'b0, y_q};
  assign stride_eff = (stride_q == 16'd0) ? x_q : stride_q;

  // Strobes follow grant combinationally so they never stay up while ownership is lost.
  assign strobe    = strobe_q & ar2dfu_grant & rst;
  assign wr_active = rst && (state == DATA) && ar2dfu_data_in_vld;

  always_comb begin
    sram_wr_en = '0;
    for (int i = 0; i < NUM_BUF; i++) begin
      sram_wr_en[i] = wr_active && (sel_q == 8'(i));
    end
  end

  assign sram_wr_addr = wr_active ? (sram_q[SRAM_AW-1:0] + beat_q) : '0;

  assign dfu2ar_wr_req           = strobe;
  assign dfu2ar_addr_vld         = strobe;
  assign dfu2ar_data_out_vld     = strobe;
  assign dfu2ar_addr             = addr_q;
  assign dfu2ar_data_out         = data_q;
  assign dfu2ar_grant_req        = grant_req_q;
  assign dfu2idu_load_instr_req  = req_q;
  assign dfu2idu_load_instr_done = done_q;
  assign dfu2idu_load_err        = err_q;
  assign dfu2ar_write_interrupt  = irq_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      sel_q       <= '0;
      stride_q    <= '0;
      dram_q      <= '0;
      sram_q      <= '0;
      src_q       <= '0;
      row_q       <= '0;
      beat_q      <= '0;
      cfg_idx     <= '0;
      strobe_q    <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      grant_req_q <= 1'b0;
      req_q       <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      req_q  <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      irq_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (!idu2dfu_load_fifo_empty) begin
            req_q <= 1'b1;
            state <= FETCH;
          end
        end
        FETCH: begin
          if (idu2dfu_load_instr_vld) begin
            x_q      <= idu2dfu_load_instr[23:8];
            y_q      <= idu2dfu_load_instr[39:24];
            sel_q    <= idu2dfu_load_instr[47:40];
            stride_q <= idu2dfu_load_instr[63:48];
            dram_q   <= idu2dfu_load_instr[127:64];
            sram_q   <= idu2dfu_load_instr[191:128];
            state    <= DECODE;
          end
        end
        DECODE: begin
          if (bad_sel) begin
            done_q <= 1'b1;
            err_q  <= 1'b1;
            state  <= IDLE;
          end else if (y_q == 16'd0) begin
            done_q <= 1'b1;
            state  <= IDLE;
          end else begin
            grant_req_q <= 1'b1;
            row_q       <= '0;
            beat_q      <= '0;
            src_q       <= dram_q;
            cfg_idx     <= '0;
            strobe_q    <= 1'b0;
            state       <= CFG;
          end
        end
        CFG: begin
          // strobe_q low here is either CFG entry or the one-cycle gap after an ack.
          if (!strobe_q) begin
            strobe_q <= 1'b1;
            case (cfg_idx)
              2'd0: begin
                addr_q <= CFG_BASE;
                data_q <= DATA_WIDTH'(x_q);
              end
              2'd1: begin
                addr_q <= CFG_BASE + AR_AW'(2);
                data_q <= DATA_WIDTH'(src_q);
              end
              default: begin
                addr_q <= CFG_BASE + AR_AW'(4);
                data_q <= DATA_WIDTH'(sram_q);
              end
            endcase
          end else if (ar2dfu_grant && ar2dfu_ack) begin
            strobe_q <= 1'b0;
            if (cfg_idx == 2'd2) begin
              irq_q <= 1'b1;
              state <= DATA;
            end else begin
              cfg_idx <= cfg_idx + 2'd1;
            end
          end
        end
        DATA: begin
          if (ar2dfu_data_in_vld) begin
            beat_q <= beat_q + SRAM_AW'(1);
          end
          if (ar2dfu_ack_data_done) begin
            if (more_rows) begin
              row_q   <= row_q + 16'd1;
              src_q   <= src_q + {48'd0, stride_eff};
              cfg_idx <= '0;
              state   <= CFG;
            end else begin
              done_q      <= 1'b1;
              grant_req_q <= 1'b0;
              state       <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
